// File: rtl/inst_sequencer_if.sv
// Host/control-unit signal bundle for the instruction sequencer.
interface inst_sequencer_if #(
  parameter int INST_BITS = 16
);
  logic                 inst_wr_en;
  logic [INST_BITS-1:0] inst_wr_data;
  logic                 start;
  logic                 abort;
  logic                 cu_flag;
  logic [INST_BITS-1:0] instruction;
  logic                 inst_full;
  logic                 inst_empty;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [7:0]           issue_count;

  modport master (
    output inst_wr_en, inst_wr_data, start, abort, cu_flag,
    input  instruction, inst_full, inst_empty, busy, done, overflow, issue_count
  );

  modport slave (
    input  inst_wr_en, inst_wr_data, start, abort, cu_flag,
    output instruction, inst_full, inst_empty, busy, done, overflow, issue_count
  );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction sequencer: circular instruction queue drained into a control unit
// one word per cu_flag handshake, with start/abort run control.
module inst_sequencer #(
  parameter int                   INST_BITS = 16,
  parameter int                   DEPTH     = 16,
  parameter logic [INST_BITS-1:0] IDLE_WORD = {INST_BITS{1'b0}}
) (
  input logic             clk,
  input logic             reset_n,
  inst_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_next;
  logic [INST_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic [7:0]           issue_count;
  logic                 done_q, overflow_q;
  logic                 empty, full, pop, push, drop, finish;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (!bus.abort && bus.start) state_next = RUN;
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (bus.cu_flag) begin
          if (empty) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // A pop at the same edge frees a slot, so a full queue can still accept
    push = bus.inst_wr_en && !bus.abort && (!full || pop);
    drop = bus.inst_wr_en && !bus.abort && full && !pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      issue_count <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= finish;
      if (bus.abort) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
      // A dropped push in the start cycle still leaves overflow set
      if (state == IDLE && bus.start && !bus.abort) begin
        issue_count <= '0;
        overflow_q  <= 1'b0;
      end else if (pop && issue_count != 8'hFF) begin
        issue_count <= issue_count + 8'd1;
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.inst_wr_data;
  end

  assign bus.instruction = (state == RUN && !empty) ? mem[rd_ptr] : IDLE_WORD;
  assign bus.inst_full   = full;
  assign bus.inst_empty  = empty;
  assign bus.busy        = (state == RUN);
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;
  assign bus.issue_count = issue_count;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_inst_sequencer;

  localparam logic [15:0] IDLE_WORD = 16'h0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  inst_sequencer_if #(.INST_BITS(16)) bus ();

  inst_sequencer #(.INST_BITS(16), .DEPTH(16), .IDLE_WORD(IDLE_WORD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: a plain queue plus run/done/overflow/count bookkeeping
  logic [15:0] mq[$];
  bit          m_run, m_done, m_ovf;
  int          m_cnt;

  task automatic model_reset();
    mq.delete();
    m_run  = 0;
    m_done = 0;
    m_ovf  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_edge(input bit we, input logic [15:0] wd, input bit st,
                            input bit ab, input bit cu);
    bit next_done = 0;
    bit popd;
    if (ab) begin
      mq.delete();
      m_run = 0;
    end else begin
      popd = m_run && cu && mq.size() != 0;
      if (m_run && cu && mq.size() == 0) begin
        m_run     = 0;
        next_done = 1;
      end else if (!m_run && st) begin
        m_run = 1;
        m_cnt = 0;
        m_ovf = 0;
      end
      if (popd) begin
        void'(mq.pop_front());
        if (m_cnt < 255) m_cnt++;
      end
      if (we) begin
        if (mq.size() < 16) mq.push_back(wd);
        else m_ovf = 1;
      end
    end
    m_done = next_done;
  endtask

  function automatic logic [28:0] expected();
    logic [15:0] ins;
    ins = (m_run && mq.size() != 0) ? mq[0] : IDLE_WORD;
    return {ins, 1'(mq.size() == 16), 1'(mq.size() == 0), 1'(m_run), 1'(m_done),
            1'(m_ovf), 8'(m_cnt)};
  endfunction

  function automatic logic [28:0] observed();
    return {bus.instruction, bus.inst_full, bus.inst_empty, bus.busy, bus.done,
            bus.overflow, bus.issue_count};
  endfunction

  task automatic drive_cycle(input bit we, input logic [15:0] wd, input bit st,
                             input bit ab, input bit cu);
    bus.inst_wr_en   = we;
    bus.inst_wr_data = wd;
    bus.start        = st;
    bus.abort        = ab;
    bus.cu_flag      = cu;
    @(posedge clk);
    model_edge(we, wd, st, ab, cu);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [28:0] rst_vec;
    rst_vec = {IDLE_WORD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    bus.inst_wr_en = 0; bus.inst_wr_data = '0; bus.start = 0; bus.abort = 0; bus.cu_flag = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (observed() !== rst_vec) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got %h expected %h", observed(), rst_vec);
    end
    reset_n = 1'b1;
    model_reset();
    drive_cycle(0, 16'h0, 0, 0, 0);
    vectors++;
    if (observed() !== expected()) begin
      miscompares++;
      $display("[TB] FAIL after_reset: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_basic_run();
    logic [15:0] w[3];
    for (int i = 0; i < 3; i++) w[i] = 16'($urandom_range(1, 16'hFFFF));
    for (int i = 0; i < 3; i++) drive_cycle(1, w[i], 0, 0, 0);
    drive_cycle(0, 16'h0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.instruction !== w[i] || observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL basic_issue%0d: got %h expected %h", i, bus.instruction, w[i]);
      end
      drive_cycle(0, 16'h0, 0, 0, 1);
    end
    vectors++;
    if (bus.instruction !== IDLE_WORD || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_drained: got ins=%h busy=%b done=%b expected %h 1 0",
               bus.instruction, bus.busy, bus.done, IDLE_WORD);
    end
    drive_cycle(0, 16'h0, 0, 0, 1);
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.issue_count !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL basic_done: got done=%b busy=%b cnt=%0d expected 1 0 3",
               bus.done, bus.busy, bus.issue_count);
    end
    drive_cycle(0, 16'h0, 0, 0, 1);
    vectors++;
    if (bus.done !== 1'b0 || observed() !== expected()) begin
      miscompares++;
      $display("[TB] FAIL basic_done_width: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_stall();
    logic [15:0] a, b;
    a = 16'h1A1A;
    b = 16'hB2B2;
    drive_cycle(1, a, 0, 0, 0);
    drive_cycle(1, b, 0, 0, 0);
    drive_cycle(0, 16'h0, 1, 0, 0);
    drive_cycle(0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 16'h0, 0, 0, 0);
      vectors++;
      if (bus.instruction !== b || bus.issue_count !== 8'd1) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got ins=%h cnt=%0d expected %h 1",
                 i, bus.instruction, bus.issue_count, b);
      end
    end
    drive_cycle(0, 16'h0, 0, 0, 1);
    vectors++;
    if (bus.issue_count !== 8'd2 || bus.inst_empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got cnt=%0d empty=%b expected 2 1",
               bus.issue_count, bus.inst_empty);
    end
    drive_cycle(0, 16'h0, 0, 0, 1);
    drive_cycle(0, 16'h0, 0, 0, 0);
  endtask

  task automatic test_overflow();
    logic [15:0] w[17];
    for (int i = 0; i < 17; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) drive_cycle(1, w[i], 0, 0, 0);
    vectors++;
    if (bus.inst_full !== 1'b1 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_full16: got full=%b ovf=%b expected 1 0", bus.inst_full, bus.overflow);
    end
    drive_cycle(1, w[16], 0, 0, 0);
    vectors++;
    if (bus.inst_full !== 1'b1 || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_drop17: got full=%b ovf=%b expected 1 1", bus.inst_full, bus.overflow);
    end
    drive_cycle(0, 16'h0, 1, 0, 1);
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (bus.instruction !== w[i] || observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL ovf_issue%0d: got %h expected %h", i, bus.instruction, w[i]);
      end
      drive_cycle(0, 16'h0, 0, 0, 1);
    end
    drive_cycle(0, 16'h0, 0, 0, 1);
    vectors++;
    if (bus.done !== 1'b1 || bus.issue_count !== 8'd16) begin
      miscompares++;
      $display("[TB] FAIL ovf_done: got done=%b cnt=%0d expected 1 16", bus.done, bus.issue_count);
    end
    drive_cycle(0, 16'h0, 0, 0, 0);
  endtask

  task automatic test_full_push_pop();
    logic [15:0] w[16];
    logic [15:0] got[16];
    logic [15:0] x;
    for (int i = 0; i < 16; i++) w[i] = 16'($urandom);
    x = 16'hC0DE;
    for (int i = 0; i < 16; i++) drive_cycle(1, w[i], 0, 0, 0);
    drive_cycle(0, 16'h0, 1, 0, 0);
    drive_cycle(1, x, 0, 0, 1);
    vectors++;
    if (bus.inst_full !== 1'b1 || bus.overflow !== 1'b0 || bus.instruction !== w[1]) begin
      miscompares++;
      $display("[TB] FAIL fullpp_occupancy: got full=%b ovf=%b ins=%h expected 1 0 %h",
               bus.inst_full, bus.overflow, bus.instruction, w[1]);
    end
    for (int i = 0; i < 16; i++) begin
      got[i] = bus.instruction;
      drive_cycle(0, 16'h0, 0, 0, 1);
    end
    vectors++;
    if (got[15] !== x || got[14] !== w[15]) begin
      miscompares++;
      $display("[TB] FAIL fullpp_last: got %h,%h expected %h,%h", got[14], got[15], w[15], x);
    end
    drive_cycle(0, 16'h0, 0, 0, 1);
    vectors++;
    if (bus.done !== 1'b1 || bus.issue_count !== 8'd17) begin
      miscompares++;
      $display("[TB] FAIL fullpp_done: got done=%b cnt=%0d expected 1 17", bus.done, bus.issue_count);
    end
    drive_cycle(0, 16'h0, 0, 0, 0);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) drive_cycle(1, 16'(16'h5000 + i), 0, 0, 0);
    drive_cycle(0, 16'h0, 1, 0, 0);
    drive_cycle(0, 16'h0, 0, 0, 1);
    drive_cycle(1, 16'hDEAD, 0, 1, 1);
    vectors++;
    if (bus.busy !== 1'b0 || bus.inst_empty !== 1'b1 || bus.done !== 1'b0 ||
        bus.instruction !== IDLE_WORD || bus.issue_count !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL abort_state: got busy=%b empty=%b done=%b ins=%h cnt=%0d expected 0 1 0 %h 1",
               bus.busy, bus.inst_empty, bus.done, bus.instruction, bus.issue_count, IDLE_WORD);
    end
    drive_cycle(0, 16'h0, 0, 0, 1);
    vectors++;
    if (bus.done !== 1'b0 || observed() !== expected()) begin
      miscompares++;
      $display("[TB] FAIL abort_no_done: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_saturate();
    drive_cycle(1, 16'h0001, 0, 0, 0);
    drive_cycle(1, 16'h0002, 0, 0, 0);
    drive_cycle(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 260; i++) drive_cycle(1, 16'(i + 3), 0, 0, 1);
    vectors++;
    if (bus.issue_count !== 8'd255 || observed() !== expected()) begin
      miscompares++;
      $display("[TB] FAIL saturate: got cnt=%0d expected 255", bus.issue_count);
    end
    drive_cycle(0, 16'h0, 0, 1, 0);
    drive_cycle(0, 16'h0, 0, 0, 0);
  endtask

  task automatic test_reset_midrun();
    logic [28:0] rst_vec;
    rst_vec = {IDLE_WORD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    for (int i = 0; i < 4; i++) drive_cycle(1, 16'(16'h7700 + i), 0, 0, 0);
    drive_cycle(0, 16'h0, 1, 0, 0);
    drive_cycle(0, 16'h0, 0, 0, 1);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (observed() !== rst_vec) begin
      miscompares++;
      $display("[TB] FAIL midrun_async_reset: got %h expected %h", observed(), rst_vec);
    end
    bus.cu_flag = 0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    drive_cycle(0, 16'h0, 1, 0, 1);
    vectors++;
    if (bus.busy !== 1'b1 || bus.instruction !== IDLE_WORD) begin
      miscompares++;
      $display("[TB] FAIL empty_start_run: got busy=%b ins=%h expected 1 %h",
               bus.busy, bus.instruction, IDLE_WORD);
    end
    drive_cycle(0, 16'h0, 0, 0, 1);
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.issue_count !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL empty_start_done: got done=%b busy=%b cnt=%0d expected 1 0 0",
               bus.done, bus.busy, bus.issue_count);
    end
    drive_cycle(0, 16'h0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit we, st, ab, cu;
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 99) < 55);
      st = ($urandom_range(0, 99) < 8);
      ab = ($urandom_range(0, 99) < 3);
      cu = ($urandom_range(0, 99) < 45);
      drive_cycle(we, 16'($urandom), st, ab, cu);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_run();
    test_stall();
    test_overflow();
    test_full_push_pop();
    test_abort();
    test_saturate();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
